branch_history_gshare: RTL and testbench

- Front-end stage directly upstream of the 2-bit pattern history table (PHT) in the branch predictor.
- Keeps a speculative global history register (GHR) and forms the gshare PHT read index from fetch PC XOR history.
- Holds an in-order queue of in-flight conditional branches, so each branch's original PHT index and actual outcome can be replayed to the PHT update port at resolution.
- On a mispredict, restores the speculative history from the architectural history.

---
 rtl/branch_history_gshare.sv | 111 +++++++++++
 tb/tb_branch_history_gshare.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_history_gshare.sv
// Gshare history front end: speculative/committed global history, PHT read
// index generation, and an in-order queue of in-flight branch indices that are
// replayed to the PHT update port when each branch resolves.
module branch_history_gshare #(
    parameter int HIST_W = 10,
    parameter int DEPTH  = 4,
    parameter int PC_LSB = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pred_valid,
    input  logic [31:0]       pred_pc,
    input  logic              pred_taken,
    output logic [HIST_W-1:0] pred_index,
    input  logic              resolve_valid,
    input  logic              resolve_taken,
    input  logic              resolve_mispredict,
    output logic              upd_valid,
    output logic [HIST_W-1:0] upd_index,
    output logic              upd_taken,
    output logic              full,
    output logic              empty,
    output logic [HIST_W-1:0] spec_ghr,
    output logic [HIST_W-1:0] arch_ghr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [HIST_W-1:0] queue [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;

    logic do_pop;
    logic do_flush;
    logic do_push;

    // PC bits outside the index window are intentionally not used.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pred_pc[31:PC_LSB+HIST_W], pred_pc[PC_LSB-1:0]};

    // Index and queue status are pure functions of current state and inputs.
    always_comb begin
        pred_index = pred_pc[PC_LSB +: HIST_W] ^ spec_ghr;
        full       = (count == CNT_W'(DEPTH));
        empty      = (count == '0);
        do_pop     = resolve_valid & ~empty;
        // A mispredict only means something when there is a branch to pop.
        do_flush   = do_pop & resolve_mispredict;
        // Wrong-path predictions in the flush cycle are dropped.
        do_push    = pred_valid & ~full & ~do_flush;
    end

    // Queue storage: written at the tail on every accepted prediction.
    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            queue[wr_ptr] <= pred_index;
        end
    end

    // Pointers, occupancy and both history registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            spec_ghr <= '0;
            arch_ghr <= '0;
        end else begin
            if (do_pop) begin
                arch_ghr <= {arch_ghr[HIST_W-2:0], resolve_taken};
            end
            if (do_flush) begin
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
                spec_ghr <= {arch_ghr[HIST_W-2:0], resolve_taken};
            end else begin
                if (do_push) begin
                    wr_ptr   <= wr_ptr + 1'b1;
                    spec_ghr <= {spec_ghr[HIST_W-2:0], pred_taken};
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({do_push, do_pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // Registered PHT update: strobe for one cycle after each pop, payload held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            upd_valid <= 1'b0;
            upd_index <= '0;
            upd_taken <= 1'b0;
        end else begin
            upd_valid <= do_pop;
            if (do_pop) begin
                upd_index <= queue[rd_ptr];
                upd_taken <= resolve_taken;
            end
        end
    end

endmodule

// File: tb/tb_branch_history_gshare.sv
// Directed bench for branch_history_gshare: inputs change on the falling edge,
// outputs are observed on the falling edge after each rising edge.
module tb_branch_history_gshare;

    logic        clk = 1'b0;
    logic        rst;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic [9:0]  pred_index;
    logic        resolve_valid;
    logic        resolve_taken;
    logic        resolve_mispredict;
    logic        upd_valid;
    logic [9:0]  upd_index;
    logic        upd_taken;
    logic        full;
    logic        empty;
    logic [9:0]  spec_ghr;
    logic [9:0]  arch_ghr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    branch_history_gshare #(.HIST_W(10), .DEPTH(4), .PC_LSB(2)) dut (
        .clk(clk), .rst(rst),
        .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken),
        .pred_index(pred_index),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
        .resolve_mispredict(resolve_mispredict),
        .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken),
        .full(full), .empty(empty), .spec_ghr(spec_ghr), .arch_ghr(arch_ghr)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        pred_valid = 0; pred_pc = 32'h0; pred_taken = 0;
        resolve_valid = 0; resolve_taken = 0; resolve_mispredict = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1; pred_valid = 1; pred_pc = 32'h40; pred_taken = 1;
        tick(); tick();
        rst = 0; idle();
    endtask

    task automatic push(input logic [31:0] pc, input logic tk);
        pred_valid = 1; pred_pc = pc; pred_taken = tk;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (spec_ghr !== 10'h000) begin n_fail++; $display("FAIL reset_spec: got %h want 000", spec_ghr); end
        n_checks++; if (arch_ghr !== 10'h000) begin n_fail++; $display("FAIL reset_arch: got %h want 000", arch_ghr); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", full); end
        n_checks++; if (upd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_upd_valid: got %b want 0", upd_valid); end
    endtask

    task automatic test_predict();
        push(32'h40, 1); #1;
        n_checks++; if (pred_index !== 10'h010) begin n_fail++; $display("FAIL pred1_index: got %h want 010", pred_index); end
        tick();
        n_checks++; if (spec_ghr !== 10'h001) begin n_fail++; $display("FAIL pred1_spec: got %h want 001", spec_ghr); end
        push(32'h40, 0); #1;
        n_checks++; if (pred_index !== 10'h011) begin n_fail++; $display("FAIL pred2_index: got %h want 011", pred_index); end
        tick(); idle();
        n_checks++; if (spec_ghr !== 10'h002) begin n_fail++; $display("FAIL pred2_spec: got %h want 002", spec_ghr); end
        n_checks++; if (empty !== 1'b0 || full !== 1'b0) begin n_fail++; $display("FAIL pred2_status: got empty=%b full=%b want 0 0", empty, full); end
        n_checks++; if (upd_valid !== 1'b0) begin n_fail++; $display("FAIL pred_no_upd: got %b want 0", upd_valid); end
    endtask

    task automatic test_resolve();
        resolve_valid = 1; resolve_taken = 1; resolve_mispredict = 0;
        tick(); idle();
        n_checks++; if (upd_valid !== 1'b1) begin n_fail++; $display("FAIL res1_upd_valid: got %b want 1", upd_valid); end
        n_checks++; if (upd_index !== 10'h010) begin n_fail++; $display("FAIL res1_upd_index: got %h want 010", upd_index); end
        n_checks++; if (upd_taken !== 1'b1) begin n_fail++; $display("FAIL res1_upd_taken: got %b want 1", upd_taken); end
        n_checks++; if (arch_ghr !== 10'h001) begin n_fail++; $display("FAIL res1_arch: got %h want 001", arch_ghr); end
        n_checks++; if (spec_ghr !== 10'h002) begin n_fail++; $display("FAIL res1_spec: got %h want 002", spec_ghr); end
        n_checks++; if (empty !== 1'b0) begin n_fail++; $display("FAIL res1_count1: empty got %b want 0", empty); end
        tick();
        n_checks++; if (upd_valid !== 1'b0) begin n_fail++; $display("FAIL res1_strobe_drop: got %b want 0", upd_valid); end
        n_checks++; if (upd_index !== 10'h010 || upd_taken !== 1'b1) begin n_fail++; $display("FAIL res1_hold: got %h/%b want 010/1", upd_index, upd_taken); end
        resolve_valid = 1; resolve_taken = 0;
        tick(); idle();
        n_checks++; if (upd_valid !== 1'b1 || upd_index !== 10'h011 || upd_taken !== 1'b0) begin n_fail++; $display("FAIL res2_upd: got %b/%h/%b want 1/011/0", upd_valid, upd_index, upd_taken); end
        n_checks++; if (arch_ghr !== 10'h002 || empty !== 1'b1) begin n_fail++; $display("FAIL res2_state: got arch=%h empty=%b want 002 1", arch_ghr, empty); end
    endtask

    task automatic test_mispredict();
        do_reset();
        push(32'h40, 1); tick();
        push(32'h80, 1); #1;
        n_checks++; if (pred_index !== 10'h021) begin n_fail++; $display("FAIL mp_idx2: got %h want 021", pred_index); end
        tick();
        push(32'hC0, 1); #1;
        n_checks++; if (pred_index !== 10'h033) begin n_fail++; $display("FAIL mp_idx3: got %h want 033", pred_index); end
        tick(); idle();
        n_checks++; if (spec_ghr !== 10'h007) begin n_fail++; $display("FAIL mp_spec_pre: got %h want 007", spec_ghr); end
        push(32'h100, 1);
        resolve_valid = 1; resolve_taken = 0; resolve_mispredict = 1;
        tick(); idle();
        n_checks++; if (upd_valid !== 1'b1 || upd_index !== 10'h010 || upd_taken !== 1'b0) begin n_fail++; $display("FAIL mp_upd: got %b/%h/%b want 1/010/0", upd_valid, upd_index, upd_taken); end
        n_checks++; if (arch_ghr !== 10'h000) begin n_fail++; $display("FAIL mp_arch: got %h want 000", arch_ghr); end
        n_checks++; if (spec_ghr !== 10'h000) begin n_fail++; $display("FAIL mp_spec: got %h want 000", spec_ghr); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL mp_empty: got %b want 1", empty); end
        // Queue must really be empty: a resolve now must not produce a strobe.
        resolve_valid = 1; resolve_taken = 1;
        tick(); idle();
        n_checks++; if (upd_valid !== 1'b0 || arch_ghr !== 10'h000) begin n_fail++; $display("FAIL mp_flushed: got upd=%b arch=%h want 0 000", upd_valid, arch_ghr); end
    endtask

    task automatic test_full();
        logic [9:0] exp_idx [4];
        logic [9:0] exp_arch [4];
        do_reset();
        push(32'h040, 1); tick();
        push(32'h080, 0); tick();
        push(32'h0C0, 1); tick();
        push(32'h100, 1); #1;
        n_checks++; if (pred_index !== 10'h045) begin n_fail++; $display("FAIL full_idx4: got %h want 045", pred_index); end
        tick();
        n_checks++; if (full !== 1'b1 || spec_ghr !== 10'h00B) begin n_fail++; $display("FAIL full_set: got full=%b spec=%h want 1 00b", full, spec_ghr); end
        push(32'h140, 1); tick();
        n_checks++; if (full !== 1'b1 || spec_ghr !== 10'h00B) begin n_fail++; $display("FAIL full_block: got full=%b spec=%h want 1 00b", full, spec_ghr); end
        push(32'h140, 1); resolve_valid = 1; resolve_taken = 1;
        tick(); idle();
        n_checks++; if (full !== 1'b0 || spec_ghr !== 10'h00B) begin n_fail++; $display("FAIL full_pop_only: got full=%b spec=%h want 0 00b", full, spec_ghr); end
        n_checks++; if (upd_valid !== 1'b1 || upd_index !== 10'h010 || arch_ghr !== 10'h001) begin n_fail++; $display("FAIL full_pop_upd: got %b/%h arch=%h want 1/010 001", upd_valid, upd_index, arch_ghr); end
        push(32'h140, 0); #1;
        n_checks++; if (pred_index !== 10'h05B) begin n_fail++; $display("FAIL full_refill_idx: got %h want 05b", pred_index); end
        tick(); idle();
        n_checks++; if (full !== 1'b1 || spec_ghr !== 10'h016) begin n_fail++; $display("FAIL full_refill: got full=%b spec=%h want 1 016", full, spec_ghr); end
        exp_idx  = '{10'h021, 10'h032, 10'h045, 10'h05B};
        exp_arch = '{10'h002, 10'h004, 10'h008, 10'h010};
        for (int i = 0; i < 4; i++) begin
            resolve_valid = 1; resolve_taken = 0;
            tick(); idle();
            n_checks++; if (upd_valid !== 1'b1 || upd_index !== exp_idx[i] || arch_ghr !== exp_arch[i]) begin n_fail++; $display("FAIL drain_%0d: got %b/%h arch=%h want 1/%h arch=%h", i, upd_valid, upd_index, arch_ghr, exp_idx[i], exp_arch[i]); end
        end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b want 1", empty); end
    endtask

    task automatic test_empty_wrap();
        logic [31:0] pc;
        logic [9:0]  m_spec;
        logic [9:0]  m_arch;
        logic [9:0]  m_q [$];
        logic [9:0]  want;
        resolve_valid = 1; resolve_taken = 1; resolve_mispredict = 1;
        tick(); idle();
        n_checks++; if (upd_valid !== 1'b0 || arch_ghr !== 10'h010 || spec_ghr !== 10'h016) begin n_fail++; $display("FAIL empty_resolve: got upd=%b arch=%h spec=%h want 0 010 016", upd_valid, arch_ghr, spec_ghr); end
        m_spec = 10'h016; m_arch = 10'h010;
        // One push to prime, then push+pop pairs in the same cycle, then a final pop.
        for (int i = 0; i < 11; i++) begin
            idle();
            if (i < 10) begin
                pc = 32'h1000 + 32'(i) * 32'h44;
                push(pc, i[1]);
                m_q.push_back(pc[11:2] ^ m_spec);
            end
            if (i > 0) begin
                resolve_valid = 1; resolve_taken = i[0];
            end
            tick();
            if (i < 10) m_spec = {m_spec[8:0], i[1]};
            if (i > 0) begin
                want   = m_q.pop_front();
                m_arch = {m_arch[8:0], i[0]};
                n_checks++; if (upd_valid !== 1'b1 || upd_index !== want || upd_taken !== i[0]) begin n_fail++; $display("FAIL wrap_%0d_upd: got %b/%h/%b want 1/%h/%b", i, upd_valid, upd_index, upd_taken, want, i[0]); end
                n_checks++; if (arch_ghr !== m_arch) begin n_fail++; $display("FAIL wrap_%0d_arch: got %h want %h", i, arch_ghr, m_arch); end
            end
            n_checks++; if (spec_ghr !== m_spec) begin n_fail++; $display("FAIL wrap_%0d_spec: got %h want %h", i, spec_ghr, m_spec); end
        end
        idle();
        n_checks++; if (empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL wrap_end: got empty=%b full=%b want 1 0", empty, full); end
    endtask

    initial begin
        rst = 1;
        idle();
        @(negedge clk);
        test_reset();
        test_predict();
        test_resolve();
        test_mispredict();
        test_full();
        test_empty_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
